// File: rtl/bird_motion.sv
// Purpose : owns the bird's vertical row; a flap lifts it RISE_STEPS rows, gravity drops it, bottom overrun latches dead.
// Latency : row, state and dead update on the clock edge that evaluates a step or flap; row_onehot and dead decode registers.
// Backpressure: none; pause freezes every register (flap ignored), reset still applies.
//
// Ports:
//   clk        - system clock
//   reset      - synchronous, active-high reset, highest priority
//   flap       - one-cycle pulse from the press stage
//   pause      - while high, state, counters and row hold
//   row        - registered bird row, 0 = top, ROWS-1 = bottom
//   row_onehot - combinational decode of row (bit[row] set)
//   dead       - sticky, high while in the DEAD state
module bird_motion #(
  parameter int ROWS        = 16,
  parameter int START_ROW   = 7,
  parameter int RISE_PERIOD = 2,
  parameter int FALL_PERIOD = 8,
  parameter int RISE_STEPS  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flap,
  input  logic                    pause,
  output logic [$clog2(ROWS)-1:0] row,
  output logic [ROWS-1:0]         row_onehot,
  output logic                    dead
);

  localparam int RW   = $clog2(ROWS);
  localparam int PMAX = (RISE_PERIOD > FALL_PERIOD) ? RISE_PERIOD : FALL_PERIOD;
  localparam int SW   = $clog2(PMAX + 1);
  localparam int CW   = $clog2(RISE_STEPS + 1);

  localparam logic [SW-1:0] RISE_LAST = SW'(RISE_PERIOD - 1);
  localparam logic [SW-1:0] FALL_LAST = SW'(FALL_PERIOD - 1);
  localparam logic [RW-1:0] ROW_START = RW'(START_ROW);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [CW-1:0] RISE_LOAD = CW'(RISE_STEPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2,
    DEAD = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [RW-1:0] row_nx;
  logic [SW-1:0] step_cnt, step_nx;
  logic [CW-1:0] rise_cnt, rise_nx;

  // State register, row and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      row      <= ROW_START;
      step_cnt <= '0;
      rise_cnt <= '0;
    end else begin
      state    <= state_nx;
      row      <= row_nx;
      step_cnt <= step_nx;
      rise_cnt <= rise_nx;
    end
  end

  // Next-state logic. A flap in RISE/FALL takes precedence over a step
  // firing on the same cycle, so the row never moves on a flap cycle.
  always_comb begin
    state_nx = state;
    row_nx   = row;
    step_nx  = step_cnt;
    rise_nx  = rise_cnt;
    unique case (state)
      IDLE: begin
        if (!pause && flap) begin
          state_nx = RISE;
          step_nx  = '0;
          rise_nx  = RISE_LOAD;
        end
      end
      RISE: begin
        if (!pause) begin
          if (flap) begin
            step_nx = '0;
            rise_nx = RISE_LOAD;
          end else if (step_cnt == RISE_LAST) begin
            step_nx = '0;
            // At the top the step still burns a rise count; row stays 0.
            row_nx  = (row == '0) ? '0 : row - 1'b1;
            rise_nx = rise_cnt - 1'b1;
            if (rise_cnt == CW'(1)) begin
              state_nx = FALL;
            end
          end else begin
            step_nx = step_cnt + 1'b1;
          end
        end
      end
      FALL: begin
        if (!pause) begin
          if (flap) begin
            state_nx = RISE;
            step_nx  = '0;
            rise_nx  = RISE_LOAD;
          end else if (step_cnt == FALL_LAST) begin
            step_nx = '0;
            // Falling past the bottom row kills the bird; row stays put.
            if (row == ROW_LAST) begin
              state_nx = DEAD;
            end else begin
              row_nx = row + 1'b1;
            end
          end else begin
            step_nx = step_cnt + 1'b1;
          end
        end
      end
      DEAD: begin
        // Frozen until reset.
      end
      default: begin
        state_nx = IDLE;
        row_nx   = ROW_START;
        step_nx  = '0;
        rise_nx  = '0;
      end
    endcase
  end

  // Outputs decoded from registers.
  always_comb begin
    row_onehot = {{(ROWS-1){1'b0}}, 1'b1} << row;
    dead       = (state == DEAD);
  end

endmodule

// File: tb/tb_bird_motion.sv
// Directed testbench for bird_motion with ROWS=8, START_ROW=3, RISE_PERIOD=2,
// FALL_PERIOD=4, RISE_STEPS=2. Inputs change and outputs are sampled 1 time
// unit after each rising clock edge.
module tb_bird_motion;

  logic       clk;
  logic       reset;
  logic       flap;
  logic       pause;
  logic [2:0] row;
  logic [7:0] row_onehot;
  logic       dead;

  int errors = 0;
  int checks = 0;

  bird_motion #(
    .ROWS       (8),
    .START_ROW  (3),
    .RISE_PERIOD(2),
    .FALL_PERIOD(4),
    .RISE_STEPS (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flap      (flap),
    .pause     (pause),
    .row       (row),
    .row_onehot(row_onehot),
    .dead      (dead)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_flap();
    flap = 1'b1;
    tick();
    flap = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    flap  = 1'b0;
    pause = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Reset, then idle 20 cycles: bird stays at the start row.
  task automatic test_reset();
    reset_dut();
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (row !== 3'd3 || row_onehot !== 8'b0000_1000 || dead !== 1'b0) begin
        $display("FAIL reset_idle cyc=%0d got row=%0d onehot=%b dead=%b exp row=3 onehot=00001000 dead=0",
                 i, row, row_onehot, dead);
        errors++;
      end
      tick();
    end
  endtask

  // Single flap: rise two rows at 2 clocks per row, then fall at 4 per row.
  task automatic test_single_flap();
    logic [2:0] exp_row [1:12];
    exp_row[1]  = 3'd3; exp_row[2]  = 3'd2; exp_row[3]  = 3'd2; exp_row[4]  = 3'd1;
    exp_row[5]  = 3'd1; exp_row[6]  = 3'd1; exp_row[7]  = 3'd1; exp_row[8]  = 3'd2;
    exp_row[9]  = 3'd2; exp_row[10] = 3'd2; exp_row[11] = 3'd2; exp_row[12] = 3'd3;
    reset_dut();
    pulse_flap();
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if (row !== exp_row[k] || dead !== 1'b0) begin
        $display("FAIL single_flap k=%0d got row=%0d dead=%b exp row=%0d dead=0",
                 k, row, dead, exp_row[k]);
        errors++;
      end
    end
  endtask

  // Fall from row 1 to the bottom, then overrun into DEAD.
  task automatic test_fall_dead();
    reset_dut();
    pulse_flap();
    for (int k = 1; k <= 4; k++) tick();
    checks++;
    if (row !== 3'd1) begin
      $display("FAIL fall_start got row=%0d exp row=1", row);
      errors++;
    end
    // Row 1 at edge 4; one row per 4 edges reaches 7 at edge 28.
    for (int k = 5; k <= 31; k++) begin
      tick();
      checks++;
      if (row !== 3'(1 + (k - 4) / 4) || dead !== 1'b0) begin
        $display("FAIL fall_descent k=%0d got row=%0d dead=%b exp row=%0d dead=0",
                 k, row, dead, 1 + (k - 4) / 4);
        errors++;
      end
    end
    tick();
    checks++;
    if (row !== 3'd7 || dead !== 1'b1 || row_onehot !== 8'b1000_0000) begin
      $display("FAIL dead_entry got row=%0d dead=%b onehot=%b exp row=7 dead=1 onehot=10000000",
               row, dead, row_onehot);
      errors++;
    end
    // Flaps and pause have no effect once dead.
    for (int i = 0; i < 3; i++) begin
      pulse_flap();
      tick();
      checks++;
      if (row !== 3'd7 || dead !== 1'b1) begin
        $display("FAIL dead_sticky i=%0d got row=%0d dead=%b exp row=7 dead=1", i, row, dead);
        errors++;
      end
    end
    pause = 1'b1;
    pulse_flap();
    pause = 1'b0;
    tick();
    checks++;
    if (row !== 3'd7 || dead !== 1'b1) begin
      $display("FAIL dead_pause got row=%0d dead=%b exp row=7 dead=1", row, dead);
      errors++;
    end
  endtask

  // Flap on the edge where a fall step would fire: row holds, then rises.
  task automatic test_flap_on_fall_step();
    reset_dut();
    pulse_flap();
    for (int k = 1; k <= 7; k++) tick();   // FALL, row 1, step counter 3
    pulse_flap();                           // edge 8
    checks++;
    if (row !== 3'd1) begin
      $display("FAIL flap_vs_fall_step got row=%0d exp row=1", row);
      errors++;
    end
    tick();
    checks++;
    if (row !== 3'd1) begin
      $display("FAIL flap_rise_wait got row=%0d exp row=1", row);
      errors++;
    end
    tick();
    checks++;
    if (row !== 3'd0) begin
      $display("FAIL flap_rise_step got row=%0d exp row=0", row);
      errors++;
    end
  endtask

  // Flaps every 2 cycles suppress every step; flaps every 3 saturate at row 0.
  task automatic test_back_to_back();
    reset_dut();
    pulse_flap();
    for (int k = 1; k <= 4; k++) tick();   // FALL, row 1, step counter 0
    for (int i = 0; i < 3; i++) begin
      pulse_flap();
      tick();
      checks++;
      if (row !== 3'd1) begin
        $display("FAIL flap_every2 i=%0d got row=%0d exp row=1", i, row);
        errors++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      pulse_flap();
      tick();
      tick();
      checks++;
      if (row !== 3'd0 || row_onehot !== 8'b0000_0001) begin
        $display("FAIL flap_saturate i=%0d got row=%0d onehot=%b exp row=0 onehot=00000001",
                 i, row, row_onehot);
        errors++;
      end
    end
    // One rise count left: one more step at the top, then gravity.
    tick();
    tick();
    checks++;
    if (row !== 3'd0) begin
      $display("FAIL top_last_step got row=%0d exp row=0", row);
      errors++;
    end
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (row !== 3'd1) begin
      $display("FAIL top_then_fall got row=%0d exp row=1", row);
      errors++;
    end
  endtask

  // Pause mid-RISE freezes everything (flap ignored); reset mid-FALL.
  task automatic test_pause_reset();
    reset_dut();
    pulse_flap();
    tick();                                 // RISE, step counter 1
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) flap = 1'b1;
      tick();
      flap = 1'b0;
      checks++;
      if (row !== 3'd3) begin
        $display("FAIL pause_hold i=%0d got row=%0d exp row=3", i, row);
        errors++;
      end
    end
    pause = 1'b0;
    tick();
    checks++;
    if (row !== 3'd2) begin
      $display("FAIL pause_resume got row=%0d exp row=2", row);
      errors++;
    end
    tick();
    tick();
    checks++;
    if (row !== 3'd1) begin
      $display("FAIL pause_rise2 got row=%0d exp row=1", row);
      errors++;
    end
    tick();
    tick();                                 // FALL, mid-period
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (row !== 3'd3 || dead !== 1'b0 || row_onehot !== 8'b0000_1000) begin
      $display("FAIL reset_mid_fall got row=%0d dead=%b onehot=%b exp row=3 dead=0 onehot=00001000",
               row, dead, row_onehot);
      errors++;
    end
    for (int k = 0; k < 10; k++) tick();
    checks++;
    if (row !== 3'd3) begin
      $display("FAIL reset_to_idle got row=%0d exp row=3", row);
      errors++;
    end
  endtask

  initial begin
    reset = 1'b1;
    flap  = 1'b0;
    pause = 1'b0;
    test_reset();
    test_single_flap();
    test_fall_dead();
    test_flap_on_fall_step();
    test_back_to_back();
    test_pause_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
